// File: rtl/wb_sel_stage_pkg.sv
// Shared types for the writeback select stage: FSM states, load size codes
// and the load-control capture record held while a memory result is late.
package wb_sel_stage_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam logic [RF_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_e;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2,
    LS_RSVD = 2'd3
  } ls_e;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd_addr;
    logic                 rd_we;
    ls_e                  load_size;
    logic                 load_unsigned;
    logic [1:0]           load_off;
  } wb_cap_t;

endpackage

// File: rtl/wb_sel_stage_load_ext.sv
// Load data extractor: picks byte/half/word from the low 32 bits of the
// memory channel by address offset and sign- or zero-extends to DATA_W.
module wb_sel_stage_load_ext
  import wb_sel_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  ls_e               size,
  input  logic              is_unsigned,
  input  logic [1:0]        off,
  input  logic [31:0]       data,
  output logic [DATA_W-1:0] ext_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = data[7:0];
    case (off)
      2'd0:    byte_v = data[7:0];
      2'd1:    byte_v = data[15:8];
      2'd2:    byte_v = data[23:16];
      default: byte_v = data[31:24];
    endcase
    // Offset bit 0 is ignored for halves; misalignment is not trapped here.
    half_v = off[1] ? data[31:16] : data[15:0];

    ext_c = DATA_W'(data);
    case (size)
      LS_BYTE: ext_c = is_unsigned ? DATA_W'(byte_v) : DATA_W'($signed(byte_v));
      LS_HALF: ext_c = is_unsigned ? DATA_W'(half_v) : DATA_W'($signed(half_v));
      default: ext_c = is_unsigned ? DATA_W'(data)   : DATA_W'($signed(data));
    endcase
  end

endmodule

// File: rtl/wb_sel_stage.sv
// Registered writeback stage: selects a result channel, extends load data,
// stalls while a load/IO result is late and aborts via a sticky watchdog.
module wb_sel_stage
  import wb_sel_stage_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_IDX     = 3,
  parameter int unsigned TIMEOUT_CYC = 16,
  localparam int unsigned SEL_W      = $clog2(NUM_SRC)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_dat_i,
  input  logic [RF_ADDR_W-1:0]      rd_addr_i,
  input  logic                      rd_we_i,
  input  logic [1:0]                load_size_i,
  input  logic                      load_unsigned_i,
  input  logic [1:0]                load_off_i,
  input  logic                      mem_valid_i,
  output logic                      rf_we_o,
  output logic [RF_ADDR_W-1:0]      rf_waddr_o,
  output logic [DATA_W-1:0]         rf_wdata_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  wb_cap_t           cap_q, cap_d, live_cap, ext_ctrl;
  logic              timeout_d;
  logic              wr_fire, wr_we;
  logic [RF_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, chan_sel, mem_ext;
  int unsigned       sel_lin;
  logic              sel_mem;

  assign in_ready_o = (state_q == WB_IDLE);
  assign busy_o     = (state_q == WB_WAIT_MEM);

  // Out-of-range selects fall back to channel 0.
  assign sel_lin  = (32'(sel_i) < NUM_SRC) ? 32'(sel_i) : 32'd0;
  assign sel_mem  = (sel_lin == MEM_IDX);
  assign chan_sel = src_dat_i[sel_lin*DATA_W +: DATA_W];

  assign live_cap = '{rd_addr:       rd_addr_i,
                      rd_we:         rd_we_i,
                      load_size:     ls_e'(load_size_i),
                      load_unsigned: load_unsigned_i,
                      load_off:      load_off_i};
  assign ext_ctrl = (state_q == WB_WAIT_MEM) ? cap_q : live_cap;

  wb_sel_stage_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .size        (ext_ctrl.load_size),
    .is_unsigned (ext_ctrl.load_unsigned),
    .off         (ext_ctrl.load_off),
    .data        (src_dat_i[MEM_IDX*DATA_W +: 32]),
    .ext_c       (mem_ext)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    timeout_d = timeout_o;
    wr_fire   = 1'b0;
    wr_we     = 1'b0;
    wr_addr   = rd_addr_i;
    wr_data   = chan_sel;
    case (state_q)
      WB_IDLE: begin
        if (in_valid_i) begin
          if (sel_mem && !mem_valid_i) begin
            state_d = WB_WAIT_MEM;
            cnt_d   = '0;
            cap_d   = live_cap;
          end else begin
            wr_fire = 1'b1;
            wr_we   = rd_we_i;
            wr_addr = rd_addr_i;
            wr_data = sel_mem ? mem_ext : chan_sel;
          end
        end
      end
      WB_WAIT_MEM: begin
        // A response on the final watchdog cycle still completes the write.
        if (mem_valid_i) begin
          wr_fire = 1'b1;
          wr_we   = cap_q.rd_we;
          wr_addr = cap_q.rd_addr;
          wr_data = mem_ext;
          state_d = WB_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          state_d   = WB_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= WB_IDLE;
      cnt_q      <= '0;
      cap_q      <= '0;
      timeout_o  <= 1'b0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      timeout_o <= timeout_d;
      rf_we_o   <= wr_fire && wr_we && (wr_addr != ZERO_REG);
      if (wr_fire) begin
        rf_waddr_o <= wr_addr;
        rf_wdata_o <= wr_data;
      end
    end
  end

endmodule
